// File: rtl/sa_ctrl_pkg.sv
// sa_ctrl_pkg
// Shared definitions for the systolic row sequencer:
//   - FSM state encoding (3-bit, IDLE = 0)
//   - helper functions deriving counter widths / drain length from the
//     row geometry, plus the derived constants for the default geometry
package sa_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_W = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam int MATRIX_SIZE_DFLT = 8;
  localparam int PIPE_LAT_DFLT    = MATRIX_SIZE_DFLT;

  function automatic int wcnt_bw(input int msize);
    return $clog2(msize);
  endfunction

  // Long enough for the last result to leave the row and for the
  // deepest skew lane (MATRIX_SIZE-1 registers) to flush to zero.
  function automatic int drain_cyc(input int pipe_lat, input int msize);
    return pipe_lat + msize - 1;
  endfunction

  localparam int WCNT_BW   = wcnt_bw(MATRIX_SIZE_DFLT);
  localparam int DRAIN_CYC = drain_cyc(PIPE_LAT_DFLT, MATRIX_SIZE_DFLT);

endpackage

// File: rtl/sa_skew_buf.sv
// sa_skew_buf
// Triangular delay line that applies the diagonal input skew of a
// weight-stationary systolic row. Lane k (lane 0 = most significant
// slice) passes through exactly k registers; lane 0 is a straight wire.
// Ports:
//   clk   - rising-edge clock
//   rstn  - asynchronous active-low reset, clears all delay registers
//   i_vec - unskewed vector (MATRIX_SIZE lanes of DATA_BW)
//   o_vec - skewed vector to the PE row
module sa_skew_buf #(
  parameter int DATA_BW     = 8,
  parameter int MATRIX_SIZE = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [MATRIX_SIZE*DATA_BW-1:0] i_vec,
  output logic [MATRIX_SIZE*DATA_BW-1:0] o_vec
);

  assign o_vec[(MATRIX_SIZE-1)*DATA_BW +: DATA_BW] = i_vec[(MATRIX_SIZE-1)*DATA_BW +: DATA_BW];

  for (genvar gi = 1; gi < MATRIX_SIZE; gi++) begin : g_lane
    logic [DATA_BW-1:0] r_dly [0:gi-1];

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int s = 0; s < gi; s++) r_dly[s] <= '0;
      end else begin
        r_dly[0] <= i_vec[(MATRIX_SIZE-1-gi)*DATA_BW +: DATA_BW];
        for (int s = 1; s < gi; s++) r_dly[s] <= r_dly[s-1];
      end
    end

    assign o_vec[(MATRIX_SIZE-1-gi)*DATA_BW +: DATA_BW] = r_dly[gi-1];
  end

endmodule

// File: rtl/sa_row_seq_ctrl.sv
// sa_row_seq_ctrl
// Sequencer for one horizontal systolic row of MATRIX_SIZE chained
// weight-stationary PEs. Loads MATRIX_SIZE weight words, streams num_vec
// input vectors with diagonal skew, tags row results with a valid bit
// aligned to the array latency and pulses done at job end. The row cannot
// stall, so bubbles are injected as zero data with a zero valid tag.
// Ports:
//   clk, rstn               - clock, asynchronous active-low reset
//   start, num_vec          - job start pulse and vector count (IDLE only)
//   busy, done              - job status
//   w_in, w_valid, w_ready  - weight word handshake
//   in_data, in_valid/ready - input vector handshake
//   arr_we_rl, arr_weights  - weight-load strobe and word to the row
//   arr_din                 - skewed input data to the row
//   arr_result              - row result
//   res_data, res_valid     - result passthrough and its valid tag
module sa_row_seq_ctrl
  import sa_ctrl_pkg::*;
#(
  parameter int WEIGHT_BW      = 8,
  parameter int DATA_BW        = 8,
  parameter int PARTIAL_SUM_BW = 20,
  parameter int MATRIX_SIZE    = 8,
  parameter int PIPE_LAT       = MATRIX_SIZE,
  parameter int CNT_BW         = 16
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             start,
  input  logic [CNT_BW-1:0]                num_vec,
  output logic                             busy,
  output logic                             done,
  input  logic [MATRIX_SIZE*WEIGHT_BW-1:0] w_in,
  input  logic                             w_valid,
  output logic                             w_ready,
  input  logic [MATRIX_SIZE*DATA_BW-1:0]   in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic                             arr_we_rl,
  output logic [MATRIX_SIZE*WEIGHT_BW-1:0] arr_weights,
  output logic [MATRIX_SIZE*DATA_BW-1:0]   arr_din,
  input  logic [PARTIAL_SUM_BW-1:0]        arr_result,
  output logic [PARTIAL_SUM_BW-1:0]        res_data,
  output logic                             res_valid
);

  localparam int L_WCNT_BW   = wcnt_bw(MATRIX_SIZE);
  localparam int L_DRAIN_CYC = drain_cyc(PIPE_LAT, MATRIX_SIZE);
  localparam int L_DCNT_BW   = $clog2(L_DRAIN_CYC + 1);
  localparam logic [L_WCNT_BW-1:0] WCNT_LAST = L_WCNT_BW'(MATRIX_SIZE - 1);
  localparam logic [L_DCNT_BW-1:0] DCNT_LAST = L_DCNT_BW'(L_DRAIN_CYC - 1);

  logic [2:0]                       r_state;
  logic [2:0]                       w_state_next;
  logic [L_WCNT_BW-1:0]             r_wcnt;
  logic [CNT_BW-1:0]                r_vcnt;
  logic [CNT_BW-1:0]                r_num_vec;
  logic [L_DCNT_BW-1:0]             r_dcnt;
  logic [PIPE_LAT-1:0]              r_vpipe;
  logic                             w_w_acc;
  logic                             w_in_acc;
  logic [CNT_BW-1:0]                w_vcnt_inc;
  logic [MATRIX_SIZE*DATA_BW-1:0]   w_din_gated;

  assign w_ready     = (r_state == ST_LOAD_W);
  assign in_ready    = (r_state == ST_STREAM);
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);
  assign w_w_acc     = w_valid & w_ready;
  assign w_in_acc    = in_valid & in_ready;
  assign w_vcnt_inc  = r_vcnt + CNT_BW'(1);
  assign arr_we_rl   = w_w_acc;
  assign arr_weights = w_in;
  assign res_data    = arr_result;
  assign res_valid   = r_vpipe[PIPE_LAT-1];

  // Non-accepted cycles feed zeros so bubbles contribute nothing to the row.
  assign w_din_gated = w_in_acc ? in_data : '0;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_next = ST_LOAD_W;
      ST_LOAD_W: if (w_w_acc && (r_wcnt == WCNT_LAST))
                   w_state_next = (r_num_vec == '0) ? ST_DRAIN : ST_STREAM;
      ST_STREAM: if (w_in_acc && (w_vcnt_inc == r_num_vec)) w_state_next = ST_DRAIN;
      ST_DRAIN:  if (r_dcnt == DCNT_LAST) w_state_next = ST_DONE;
      ST_DONE:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_wcnt    <= '0;
      r_vcnt    <= '0;
      r_num_vec <= '0;
      r_dcnt    <= '0;
      r_vpipe   <= '0;
    end else begin
      r_state <= w_state_next;

      if ((r_state == ST_IDLE) && start) r_num_vec <= num_vec;

      if (w_w_acc) r_wcnt <= (r_wcnt == WCNT_LAST) ? '0 : r_wcnt + L_WCNT_BW'(1);

      if (r_state == ST_IDLE) r_vcnt <= '0;
      else if (w_in_acc)      r_vcnt <= w_vcnt_inc;

      if (r_state == ST_DRAIN) r_dcnt <= (r_dcnt == DCNT_LAST) ? '0 : r_dcnt + L_DCNT_BW'(1);
      else                     r_dcnt <= '0;

      // Valid tag travels alongside the vector through the row.
      r_vpipe[0] <= w_in_acc;
      for (int i = 1; i < PIPE_LAT; i++) r_vpipe[i] <= r_vpipe[i-1];
    end
  end

  sa_skew_buf #(
    .DATA_BW     (DATA_BW),
    .MATRIX_SIZE (MATRIX_SIZE)
  ) u_skew (
    .clk   (clk),
    .rstn  (rstn),
    .i_vec (w_din_gated),
    .o_vec (arr_din)
  );

endmodule

// File: tb/tb_sa_row_seq_ctrl.sv
// tb_sa_row_seq_ctrl
// Self-checking bench: a behavioural weight-stationary PE row closes the
// loop, a scoreboard queues the expected sum and arrival cycle for each
// accepted vector and compares when res_valid is seen.
module tb_sa_row_seq_ctrl;

  localparam int WB = 8;
  localparam int DB = 8;
  localparam int PB = 20;
  localparam int MS = 8;
  localparam int PL = MS;
  localparam int CB = 16;

  logic              clk;
  logic              rstn;
  logic              start;
  logic [CB-1:0]     num_vec;
  logic              busy;
  logic              done;
  logic [MS*WB-1:0]  w_in;
  logic              w_valid;
  logic              w_ready;
  logic [MS*DB-1:0]  in_data;
  logic              in_valid;
  logic              in_ready;
  logic              arr_we_rl;
  logic [MS*WB-1:0]  arr_weights;
  logic [MS*DB-1:0]  arr_din;
  logic [PB-1:0]     arr_result;
  logic [PB-1:0]     res_data;
  logic              res_valid;

  sa_row_seq_ctrl #(
    .WEIGHT_BW(WB), .DATA_BW(DB), .PARTIAL_SUM_BW(PB),
    .MATRIX_SIZE(MS), .PIPE_LAT(PL), .CNT_BW(CB)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .num_vec(num_vec),
    .busy(busy), .done(done),
    .w_in(w_in), .w_valid(w_valid), .w_ready(w_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .arr_we_rl(arr_we_rl), .arr_weights(arr_weights), .arr_din(arr_din),
    .arr_result(arr_result), .res_data(res_data), .res_valid(res_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [PB-1:0] mulw(input logic signed [DB-1:0] d,
                                                input logic signed [WB-1:0] w);
    mulw = d * w;
  endfunction

  function automatic logic [PB-1:0] exp_sum(input logic [MS*DB-1:0] dv,
                                            input logic [MS*WB-1:0] wv);
    logic signed [PB-1:0] acc;
    acc = '0;
    for (int k = 0; k < MS; k++)
      acc = acc + mulw(dv[(MS-1-k)*DB +: DB], wv[(MS-1-k)*WB +: WB]);
    return acc;
  endfunction

  // Behavioural PE row: PE k latches its weight lane, adds din_k*w_k to
  // the partial sum from PE k-1; last PE output is the row result.
  logic signed [WB-1:0] pw [MS];
  logic signed [PB-1:0] ps [MS];
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < MS; k++) ps[k] <= '0;
    end else begin
      if (arr_we_rl)
        for (int k = 0; k < MS; k++) pw[k] <= arr_weights[(MS-1-k)*WB +: WB];
      ps[0] <= mulw(arr_din[(MS-1)*DB +: DB], pw[0]);
      for (int k = 1; k < MS; k++)
        ps[k] <= ps[k-1] + mulw(arr_din[(MS-1-k)*DB +: DB], pw[k]);
    end
  end
  assign arr_result = ps[MS-1];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [PB-1:0] val;
    int            cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e_pop;

  int              cyc = 0;
  int              we_cnt = 0, done_cnt = 0, irdy_cnt = 0;
  int              base_we, base_done, base_irdy;
  logic [MS*WB-1:0] exp_w = '0;
  logic [PB-1:0]   last_res = '0;
  logic            s_busy, s_done, s_w_ready, s_in_ready, s_we, s_res_valid, s_wacc, s_iacc;
  logic [MS*DB-1:0] s_arr_din;

  // One clock cycle: sample/score at the falling edge, then return 1ns
  // after the next rising edge so the caller can drive new inputs.
  task automatic step();
    @(negedge clk);
    s_busy = busy; s_done = done; s_w_ready = w_ready; s_in_ready = in_ready;
    s_we = arr_we_rl; s_res_valid = res_valid; s_arr_din = arr_din;
    s_wacc = w_valid && w_ready;
    s_iacc = in_valid && in_ready;
    if (!rstn) begin
      sb.delete();
    end else begin
      if (res_valid) begin
        if (sb.size() == 0) begin
          chk("res_spurious", 1, 0);
        end else begin
          e_pop = sb.pop_front();
          chk("res_cycle", cyc, e_pop.cyc);
          chk("res_data", res_data, e_pop.val);
          last_res = res_data;
        end
      end
      if (arr_we_rl) we_cnt++;
      if (s_wacc) exp_w = w_in;
      if (done) done_cnt++;
      if (in_ready) irdy_cnt++;
      if (s_iacc) sb.push_back('{exp_sum(in_data, exp_w), cyc + PL});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_start(input logic [CB-1:0] nv);
    base_we = we_cnt; base_done = done_cnt; base_irdy = irdy_cnt;
    start = 1'b1; num_vec = nv;
    step();
    start = 1'b0;
    step();
    chk("w_ready_after_start", s_w_ready, 1);
    chk("busy_after_start", s_busy, 1);
  endtask

  task automatic do_load(input logic [MS*WB-1:0] wv, input bit toggle);
    int acc = 0;
    int n = 0;
    bit ph = 1'b0;
    // do_start already spent one LOAD_W cycle with w_valid low
    while (acc < MS && n < 64) begin
      w_in = wv;
      w_valid = toggle ? ph : 1'b1;
      ph = !ph;
      step();
      if (s_wacc) acc++;
      n++;
    end
    w_valid = 1'b0;
    chk("load_accepts", acc, MS);
  endtask

  task automatic do_stream(input logic [MS*DB-1:0] dv, input int nv, input logic [31:0] pat,
                           input int plen, input int st_idx, input bit tail);
    int acc = 0;
    int i = 0;
    int extra = 0;
    while (acc < nv && i < 200) begin
      in_data = dv;
      in_valid = pat[i % plen];
      if (i == st_idx) begin start = 1'b1; num_vec = 16'd7; end
      else start = 1'b0;
      step();
      if (s_iacc) acc++;
      i++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    chk("stream_accepts", acc, nv);
    if (tail) begin
      in_valid = 1'b1;
      repeat (3) begin
        step();
        if (s_iacc) extra++;
      end
      in_valid = 1'b0;
      chk("no_extra_accepts", extra, 0);
    end
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    int n = 0;
    while (!seen && n < 64) begin
      step();
      if (s_done) seen = 1'b1;
      n++;
    end
    chk("done_seen", seen, 1);
    step();
    chk("busy_low_after_done", s_busy, 0);
    repeat (2) step();
    chk("done_pulses", done_cnt - base_done, 1);
    chk("scoreboard_empty", sb.size(), 0);
  endtask

  logic [MS*WB-1:0] ones_w, rnd_w;
  logic [MS*DB-1:0] twos_d, lane_d, rnd_d;

  initial begin
    rstn = 1'b0; start = 1'b0; num_vec = '0; w_in = '0; w_valid = 1'b0;
    in_data = '0; in_valid = 1'b0;
    for (int k = 0; k < MS; k++) begin
      ones_w[k*WB +: WB] = 8'd1;
      twos_d[k*DB +: DB] = 8'd2;
      lane_d[(MS-1-k)*DB +: DB] = DB'(k + 1);
      rnd_w[k*WB +: WB] = WB'($urandom_range(0, 255));
      rnd_d[k*DB +: DB] = DB'($urandom_range(0, 255));
    end
    #1;
    repeat (3) step();
    chk("rst_busy", s_busy, 0);
    chk("rst_done", s_done, 0);
    chk("rst_w_ready", s_w_ready, 0);
    chk("rst_in_ready", s_in_ready, 0);
    chk("rst_we", s_we, 0);
    chk("rst_res_valid", s_res_valid, 0);
    chk("rst_arr_din", s_arr_din, 0);
    rstn = 1'b1;
    step();

    // Job 1: toggling weight valid, four all-2 vectors back to back
    do_start(16'd4);
    do_load(ones_w, 1'b1);
    chk("t1_we_pulses", we_cnt - base_we, MS);
    do_stream(twos_d, 4, 32'h1, 1, -1, 1'b1);
    wait_done();
    chk("t1_result_16", last_res, 16);

    // Job 2: skew check, lane k carries k+1
    do_start(16'd1);
    do_load(ones_w, 1'b0);
    in_data = lane_d; in_valid = 1'b1;
    step();
    chk("t2_accept", s_iacc, 1);
    in_valid = 1'b0; in_data = '0;
    for (int j = 0; j < MS + 1; j++) begin
      if (j > 0) step();
      for (int k = 0; k < MS; k++)
        chk($sformatf("t2_skew_o%0d_l%0d", j, k), s_arr_din[(MS-1-k)*DB +: DB],
            (j == k) ? 64'(k + 1) : 64'd0);
    end
    wait_done();
    chk("t2_result_36", last_res, 36);

    // Job 3: random signed weights/data, valid pattern 1,0,0,1
    do_start(16'd2);
    do_load(rnd_w, 1'b0);
    do_stream(rnd_d, 2, 32'b1001, 4, -1, 1'b1);
    wait_done();

    // Job 4: zero vectors
    do_start(16'd0);
    do_load(ones_w, 1'b0);
    wait_done();
    chk("t4_in_ready_never", irdy_cnt - base_irdy, 0);

    // Job 5: reset after 2 of 5 vectors
    do_start(16'd5);
    do_load(ones_w, 1'b0);
    do_stream(twos_d, 2, 32'h1, 1, -1, 1'b0);
    rstn = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_w_ready", w_ready, 0);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_we", arr_we_rl, 0);
    chk("t5_res_valid", res_valid, 0);
    chk("t5_arr_din", arr_din, 0);
    repeat (2) step();
    rstn = 1'b1;
    repeat (12) step();
    chk("t5_no_done", done_cnt - base_done, 0);
    do_start(16'd3);
    do_load(ones_w, 1'b0);
    do_stream(rnd_d, 3, 32'b011, 3, -1, 1'b1);
    wait_done();

    // Job 6: start with another count while streaming is ignored
    do_start(16'd3);
    do_load(ones_w, 1'b0);
    do_stream(twos_d, 3, 32'h1, 1, 1, 1'b1);
    wait_done();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sa_row_seq_ctrl.md
# sa_row_seq_ctrl

Sequencer for one horizontal systolic row (MATRIX_SIZE chained weight-stationary PEs). It loads MATRIX_SIZE weight words into the row, then streams `num_vec` input vectors with per-lane diagonal skew. It tags each row result with a valid bit aligned to the array latency and signals completion. It sits between the input/weight buffers and the PE row; the row itself has no stall input, so all flow control lives here.

## Interface
- `WEIGHT_BW`, 8, weight element width
- `DATA_BW`, 8, input element width
- `PARTIAL_SUM_BW`, 20, row result width
- `MATRIX_SIZE`, 8, PEs per row (lanes); power of two, ≥2
- `PIPE_LAT`, MATRIX_SIZE, cycles from lane-0 injection to row result
- `CNT_BW`, 16, width of vector counter
- `clk` in 1 — rising-edge clock
- `rstn` in 1 — asynchronous, active-low reset
- `start` in 1 — job start pulse; sampled only in IDLE
- `num_vec` in CNT_BW — vectors in job; sampled with `start`
- `busy` out 1 — high in every state except IDLE
- `done` out 1 — one-cycle pulse at job end
- `w_in` in MATRIX_SIZE*WEIGHT_BW — weight word
- `w_valid` / `w_ready` in/out 1 — weight handshake
- `in_data` in MATRIX_SIZE*DATA_BW — input vector
- `in_valid` / `in_ready` in/out 1 — input handshake
- `arr_we_rl` out 1 — weight-load enable to row
- `arr_weights` out MATRIX_SIZE*WEIGHT_BW — equals `w_in`
- `arr_din` out MATRIX_SIZE*DATA_BW — skewed data to row
- `arr_result` in PARTIAL_SUM_BW — row result
- `res_data` out PARTIAL_SUM_BW — equals `arr_result`
- `res_valid` out 1 — `res_data` belongs to a real vector

## Operation
- Lane k (0 = first PE in chain) occupies bits [(MATRIX_SIZE-1-k)*DATA_BW +: DATA_BW] on `in_data`/`arr_din`; same mapping on weights.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, DONE.
  - IDLE: `start`=1 latches `num_vec` and goes to LOAD_W.
  - LOAD_W: `w_ready`=1. `arr_we_rl` = `w_valid & w_ready`. Weight counter counts accepts. After the MATRIX_SIZE-th accept, go to STREAM, or to DRAIN if `num_vec`=0.
  - STREAM: `in_ready`=1. Each accept increments the vector counter. The accept of vector `num_vec` moves to DRAIN.
  - DRAIN: `in_ready`=0. Wait PIPE_LAT+MATRIX_SIZE-1 cycles (drain counter), then go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- Skew: lane 0 is injected the same cycle it is accepted (combinational: accepted data, else zero). Lane k passes through k registers. The skew registers shift every cycle in every state.
- Bubbles: a STREAM cycle without accept injects zero on lane 0 and a 0 into the valid pipe. The array never stalls.
- Valid pipe: PIPE_LAT-deep shift register fed by `in_valid & in_ready`. Its output is `res_valid`.
- `arr_we_rl`=0 outside LOAD_W. `w_ready`/`in_ready` are 0 outside their states.
- `start` while `busy` is ignored.
- Result arithmetic belongs to the row (signed sum of din*w). This block does not modify `arr_result`.

## Timing
- Reset values:
  - FSM = IDLE
  - all counters 0
  - skew registers and valid pipe 0
  - `busy`, `done`, `w_ready`, `in_ready`, `arr_we_rl`, `res_valid` = 0
  - `arr_din` = 0
- `start` at edge n puts the FSM in LOAD_W; `w_ready`=1 from cycle n+1.
- A vector accepted at cycle t gives `res_valid`=1 at cycle t+PIPE_LAT. For back-to-back accepts, the results are back-to-back.
- The last result appears at most PIPE_LAT cycles after the last accept. Remaining DRAIN cycles flush the skew so the next job starts clean.
- `busy` falls the cycle after DONE.
- Async reset mid-job: immediate return to reset values, with no `done`. In-flight results are discarded (`res_valid`=0).

## Structure
- Package `sa_ctrl_pkg`: FSM state encoding (3-bit, IDLE=0), and the derived constants WCNT_BW=$clog2(MATRIX_SIZE) and DRAIN_CYC.
- Sub-module `sa_skew_buf`: triangular delay line. Parameters: DATA_BW, MATRIX_SIZE. Ports: `clk`, `rstn`, vector in, vector out. Lane k has k registers.
- The FSM, counters and valid pipe live in the top.

## Test plan
- Weights all 1, `w_valid` toggling 1/0 → exactly 8 `arr_we_rl` pulses, then STREAM. Stream `in_data` all 2, `num_vec`=4 → four `res_valid` pulses with `res_data`=16, the first 8 cycles after the first accept.
- Input skew check with `in_data` lane k = k+1 → `arr_din` lane k shows k+1 exactly k cycles after the accept, and zero otherwise.
- `in_valid` pattern 1,0,0,1 with `num_vec`=2 → `res_valid` pattern 1,0,0,1 shifted by PIPE_LAT, then one `done`.
- `num_vec`=0 → weight load, DRAIN, single `done`, no `res_valid`, `in_ready` never high.
- `rstn` low during STREAM after 2 of 5 vectors → all outputs return to reset values at once, no `done`. A new `start` then runs normally.
- `start` pulsed during STREAM with different `num_vec` → ignored; the original count completes.
